// File: rtl/uart_pkg.sv
// Shared UART constants: the 13-entry baud table, its default index and the
// rate-select type used by baud_gen_multi and baud_tick_core.
package uart_pkg;

  localparam int NUM_BAUDS   = 13;
  localparam int DEFAULT_IDX = 3;

  typedef logic [3:0] baud_sel_t;

  localparam int unsigned BAUD_TABLE [NUM_BAUDS] = '{
    1200, 2400, 4800, 9600, 19200, 28800, 38400,
    57600, 76800, 115200, 230400, 460800, 921600
  };

  // Indices past the end of the table fall back to the default rate.
  function automatic int unsigned baud_rate(input baud_sel_t idx);
    int unsigned r;
    r = BAUD_TABLE[DEFAULT_IDX];
    for (int i = 0; i < NUM_BAUDS; i++) begin
      if (idx == baud_sel_t'(i)) r = BAUD_TABLE[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/baud_tick_core.sv
// Oversample tick source: integer divider by default, or a phase accumulator
// when BAUD_FRAC_EN is defined. Per-rate constants are folded at elaboration.
module baud_tick_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      en,
  input  baud_sel_t rate,
  output logic      tick
);

`ifdef BAUD_FRAC_EN

  localparam logic [ACC_W:0] CLK_C = (ACC_W+1)'(CLK_FREQ);

  logic [ACC_W-1:0] inc_tab [16];
  logic [ACC_W-1:0] acc;
  logic [ACC_W:0]   sum;

  for (genvar i = 0; i < 16; i++) begin : g_inc
    localparam longint INC = longint'(baud_rate(baud_sel_t'(i))) * longint'(OVERSAMPLE);
    assign inc_tab[i] = ACC_W'(INC);
  end

  // One spare bit so acc+inc never wraps before the compare.
  assign sum = {1'b0, acc} + {1'b0, inc_tab[rate]};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= CLK_C) begin
      acc  <= ACC_W'(sum - CLK_C);
      tick <= 1'b1;
    end else begin
      acc  <= sum[ACC_W-1:0];
      tick <= 1'b0;
    end
  end

`else

  logic [ACC_W-1:0] div_tab [16];
  logic [ACC_W-1:0] cnt;
  logic [ACC_W-1:0] last;

  for (genvar i = 0; i < 16; i++) begin : g_div
    localparam longint DIV_RAW =
      longint'(CLK_FREQ) / (longint'(baud_rate(baud_sel_t'(i))) * longint'(OVERSAMPLE));
    assign div_tab[i] = (DIV_RAW < 1) ? ACC_W'(1) : ACC_W'(DIV_RAW);
  end

  assign last = div_tab[rate] - ACC_W'(1);

  // >= rather than == so a rate switch to a shorter divisor can never skip the wrap.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt >= last) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + ACC_W'(1);
      tick <= 1'b0;
    end
  end

`endif

endmodule

// File: rtl/baud_gen_multi.sv
// Multi-rate baud generator: select latching, oversample counting and strobes.
// Define BAUD_FRAC_EN to use the fractional phase-accumulator tick core.
module baud_gen_multi
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int OVERSAMPLE = 16,
  parameter int ACC_W      = 32
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      en,
  input  baud_sel_t baud_sel,
  output logic      tick,
  output logic      bit_tick,
  output logic      sel_err
);

  localparam int              OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

  baud_sel_t       act_sel;
  baud_sel_t       rate;
  logic [OS_W-1:0] os_cnt;

  // Only pick up a new rate at a period boundary (or while idle).
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      act_sel <= baud_sel_t'(DEFAULT_IDX);
    end else if (!en || tick) begin
      act_sel <= baud_sel;
    end
  end

  assign sel_err = (act_sel >= baud_sel_t'(NUM_BAUDS));
  assign rate    = sel_err ? baud_sel_t'(DEFAULT_IDX) : act_sel;

  baud_tick_core #(
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(OVERSAMPLE),
    .ACC_W     (ACC_W)
  ) u_core (
    .clk   (clk),
    .arst_n(arst_n),
    .en    (en),
    .rate  (rate),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      os_cnt <= '0;
    end else if (!en) begin
      os_cnt <= '0;
    end else if (tick) begin
      os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end
  end

  assign bit_tick = tick && (os_cnt == OS_LAST);

endmodule

// File: tb/tb_baud_gen_multi.sv
// Self-checking bench for baud_gen_multi: per-cycle compare against a rate model,
// directed spacing checks, and randomized enable/select segments.
module tb_baud_gen_multi;

  localparam int CLK = 50_000_000;
  localparam int OS  = 16;
`ifdef BAUD_FRAC_EN
  localparam longint FIRST3 = 326;
`else
  localparam longint FIRST3 = 325;
`endif

  localparam int unsigned BAUDS [13] = '{
    1200, 2400, 4800, 9600, 19200, 28800, 38400,
    57600, 76800, 115200, 230400, 460800, 921600
  };

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       en = 1'b0;
  logic [3:0] baud_sel = 4'd3;
  logic       tick, bit_tick, sel_err;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint cyc     = 0;

  baud_gen_multi #(.CLK_FREQ(CLK), .OVERSAMPLE(OS), .ACC_W(32)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .baud_sel(baud_sel),
    .tick(tick), .bit_tick(bit_tick), .sel_err(sel_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint eff_baud(input int idx);
    return (idx > 12) ? longint'(BAUDS[3]) : longint'(BAUDS[idx]);
  endfunction

  function automatic longint div_of(input int idx);
    longint d;
    d = longint'(CLK) / (eff_baud(idx) * OS);
    return (d < 1) ? 1 : d;
  endfunction

  // Reference: active rate, enabled edges since period start (integer) or since clear (fractional).
  int     m_act   = 3;
  longint m_n     = 0;
  longint m_ticks = 0;
  bit     m_tick  = 1'b0;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_act = 3; m_n = 0; m_ticks = 0; m_tick = 1'b0;
    end else if (!en) begin
      m_act = int'(baud_sel); m_n = 0; m_ticks = 0; m_tick = 1'b0;
    end else begin
      if (m_tick) m_act = int'(baud_sel);
`ifdef BAUD_FRAC_EN
      m_n++;
      m_tick = ((m_n * eff_baud(m_act) * OS) / CLK) != (((m_n - 1) * eff_baud(m_act) * OS) / CLK);
`else
      m_n++;
      if (m_n == div_of(m_act)) begin
        m_tick = 1'b1;
        m_n = 0;
      end else begin
        m_tick = 1'b0;
      end
`endif
      if (m_tick) m_ticks++;
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic compare_loop();
    logic [2:0] exp_v, got_v;
    forever begin
      @(negedge clk);
      exp_v = {m_tick, m_tick && (m_ticks > 0) && ((m_ticks % OS) == 0), m_act > 12};
      got_v = {tick, bit_tick, sel_err};
      n_tests++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL cycle_compare at cycle %0d: got tick/bit_tick/sel_err=%b, required %b",
                 cyc, got_v, exp_v);
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic next_strobe(input bit want_bit, input int budget, output longint t);
    bit got;
    got = 1'b0;
    t = 0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      #1;
      if (want_bit ? bit_tick : tick) begin
        got = 1'b1;
        t = cyc;
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL strobe_timeout: none within %0d cycles, required one", budget);
    end
  endtask

  initial begin
    longint     t0, tp, t;
    int         cnt;
    bit         en_n;
    logic [3:0] sel_n;

    fork
      compare_loop();
    join_none

    #1 arst_n = 1'b0;
    cycles(5);
    check("reset_outputs", longint'({tick, bit_tick, sel_err}), 0);
    arst_n = 1'b1;
    cycles(2);

    en = 1'b1;
    t0 = cyc;
    next_strobe(1'b0, 2000, t);
    check("first_tick_sel3", t - t0, FIRST3);

`ifndef BAUD_FRAC_EN
    tp = t;
    next_strobe(1'b0, 2000, t);
    check("tick_gap_sel3", t - tp, 325);
    next_strobe(1'b1, 6000, tp);
    next_strobe(1'b1, 6000, t);
    check("bit_gap_sel3", t - tp, 5200);

    // 3 -> 9 requested mid-period: current period finishes at 325, then 27.
    tp = t;
    cycles(100);
    baud_sel = 4'd9;
    next_strobe(1'b0, 2000, t);
    check("change_completes", t - tp, 325);
    tp = t;
    next_strobe(1'b0, 2000, t);
    check("tick_gap_sel9", t - tp, 27);
    check("sel_err_sel9", longint'(sel_err), 0);

    tp = t;
    cycles(5);
    baud_sel = 4'd14;
    next_strobe(1'b0, 2000, t);
    check("gap_before_latch14", t - tp, 27);
    tp = t;
    cycles(1);
    check("sel_err_sel14", longint'(sel_err), 1);
    next_strobe(1'b0, 2000, t);
    check("tick_gap_sel14", t - tp, 325);
`endif

    cycles(50);
    en = 1'b0;
    baud_sel = 4'd3;
    cnt = 0;
    repeat (10) begin
      cycles(1);
      if (tick || bit_tick) cnt++;
    end
    check("no_strobe_disabled", cnt, 0);
    en = 1'b1;
    t0 = cyc;
    next_strobe(1'b0, 2000, t);
    check("first_tick_reenable", t - t0, FIRST3);

    cycles(100);
    arst_n = 1'b0;
    cnt = 0;
    repeat (5) begin
      cycles(1);
      if (tick || bit_tick) cnt++;
    end
    check("no_strobe_reset", cnt, 0);
    check("sel_err_reset", longint'(sel_err), 0);
    arst_n = 1'b1;
    t0 = cyc;
    next_strobe(1'b0, 2000, t);
    check("first_tick_post_reset", t - t0, FIRST3);

`ifdef BAUD_FRAC_EN
    begin
      int     n_tk, n_bt, bad;
      longint last;
      en = 1'b0;
      baud_sel = 4'd3;
      cycles(3);
      en = 1'b1;
      n_tk = 0; n_bt = 0; bad = 0; last = -1;
      for (int i = 0; i < 1000000; i++) begin
        @(negedge clk);
        #1;
        if (tick) begin
          if (last >= 0 && (cyc - last) != 325 && (cyc - last) != 326) bad++;
          last = cyc;
          n_tk++;
        end
        if (bit_tick) n_bt++;
      end
      check("frac_tick_count", n_tk, 3072);
      check("frac_bit_count", n_bt, 192);
      check("frac_spacing_violations", bad, 0);
    end
`endif

    for (int s = 0; s < 20; s++) begin
      en_n  = ($urandom_range(0, 3) != 0);
      sel_n = 4'($urandom_range(0, 15));
`ifdef BAUD_FRAC_EN
      if (!en_n) begin
        en = 1'b0;
        baud_sel = sel_n;
      end else begin
        en = 1'b1;
      end
`else
      en = en_n;
      baud_sel = sel_n;
`endif
      cycles($urandom_range(20, 2500));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/baud_gen_multi.md
BAUD_GEN_MULTI -- requirements
Module: baud_gen_multi

Interface
- REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning system clock frequency in Hz.
- REQ-002 SHALL have parameter OVERSAMPLE, default 16, meaning ticks per bit period; legal range 4..32.
- REQ-003 SHALL have parameter ACC_W, default 32, meaning divider/accumulator width in bits.
- REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic rising-edge.
- REQ-005 SHALL have port arst_n, input, 1, meaning reset; asynchronous, active-low.
- REQ-006 SHALL have port en, input, 1, meaning generator enable.
- REQ-007 SHALL have port baud_sel, input, 4, meaning rate select index into the 13-entry table.
- REQ-008 SHALL have port tick, output, 1, meaning oversample strobe at baud*OVERSAMPLE, one cycle wide.
- REQ-009 SHALL have port bit_tick, output, 1, meaning bit-rate strobe, one cycle wide.
- REQ-010 SHALL have port sel_err, output, 1, meaning the active selection was out of range.

Function
- REQ-011 SHALL use table 1200,2400,4800,9600,19200,28800,38400,57600,76800,115200,230400,460800,921600 for indices 0..12.
- REQ-012 SHALL treat baud_sel 13..15 as index 3 (9600) and set sel_err=1 while that selection is active.
- REQ-013 SHALL latch baud_sel into an active-select register only when en=0 or in the cycle tick is generated, so a rate change never truncates a period.
- REQ-014 SHALL, in integer mode, compute DIV = CLK_FREQ/(BAUD*OVERSAMPLE) (truncating); counter runs 0..DIV-1, wraps to 0.
- REQ-015 SHALL register tick high for exactly one cycle per counter wrap; first tick occurs DIV enabled clocks after en is first sampled high.
- REQ-016 SHALL count ticks modulo OVERSAMPLE and assert bit_tick in the same cycle as every OVERSAMPLE-th tick.
- REQ-017 SHALL, when en=0, clear the divider, accumulator, and oversample counters and drive tick=bit_tick=0 from the next edge.
- REQ-018 SHALL clamp DIV to a minimum of 1 (tick every clock) if the computed DIV is 0.
- REQ-019 SHALL keep all arithmetic within ACC_W bits without overflow for all table entries at the default CLK_FREQ.

Reset
- REQ-020 SHALL, on arst_n low, immediately force tick=0, bit_tick=0, sel_err=0, all counters and the accumulator to 0, and the active select to 3.
- REQ-021 SHALL resume counting from zero on the first enabled edge after arst_n deasserts; reset mid-period discards the partial period.

Configuration
- REQ-022 SHALL, with macro BAUD_FRAC_EN defined, replace the integer divider with a phase accumulator: inc = BAUD*OVERSAMPLE; if acc+inc >= CLK_FREQ, then acc <= acc+inc-CLK_FREQ and tick; otherwise acc <= acc+inc.
- REQ-023 SHALL, with BAUD_FRAC_EN undefined, use the integer divider of REQ-014; ports and all other behaviour are identical in both builds.

Structure
- REQ-024 SHALL place the baud table, the NUM_BAUDS=13 constant, the default index, and the baud_sel_t typedef in the shared package uart_pkg.
- REQ-025 SHALL implement the divider/accumulator as sub-module baud_tick_core (inputs en, active rate; output tick); oversample counting and select latching stay in baud_gen_multi.

Verification
- REQ-026 SHALL test integer build, CLK_FREQ=50e6, baud_sel=3, en=1: tick every 325 clocks and bit_tick every 5200 clocks.
- REQ-027 SHALL test integer build with baud_sel=9: tick every 27 clocks, with sel_err=0.
- REQ-028 SHALL test baud_sel=14: sel_err=1 after the next latch point, and tick every 325 clocks.
- REQ-029 SHALL test a change of baud_sel from 3 to 9 mid-period: the current 325-clock period completes, then the tick spacing becomes 27.
- REQ-030 SHALL test the BAUD_FRAC_EN build with baud_sel=3 over 1,000,000 clocks: exactly 3072 ticks and 192 bit_ticks, with tick spacing 325 or 326 only.
- REQ-031 SHALL test en dropped for 10 cycles, and arst_n pulsed mid-period: no strobes while disabled or in reset, and the first tick comes DIV clocks after re-enable.
